// File: rtl/best_1ofn_pipe.sv
// Best-1-of-NPAT pattern sorter: compare-by-twos tree with per-stage optional pipeline registers,
// thresholded valid and saturating qualified-result counter. Optional tie flag: BEST_1OFN_TIE_FLAG_EN.
module best_1ofn_pipe #(
    parameter int unsigned NPAT = 32,
    parameter int unsigned MXPATB = 7,
    parameter int unsigned SORT_LSB = 1,
    parameter logic [7:0] PIPE_MASK = 8'b00001000,
    parameter int unsigned MXCNTB = 16,
    localparam int unsigned MXKEYB = $clog2(NPAT)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NPAT*MXPATB-1:0]     pat_in,
    input  logic                       pat_vld_in,
    input  logic [MXPATB-SORT_LSB-1:0] thresh,
    input  logic                       cnt_clr,
    output logic [MXPATB-1:0]          best_pat,
    output logic [MXKEYB-1:0]          best_key,
    output logic                       best_vld,
`ifdef BEST_1OFN_TIE_FLAG_EN
    output logic                       best_tie,
`endif
    output logic [MXCNTB-1:0]          best_cnt
);

    localparam int unsigned NSTG = MXKEYB;
    localparam int unsigned NNODE = 2 * NPAT - 1;

    // Heap-style node buses: level l starts at node 2*NPAT - 2*(NPAT>>l); level 0 is the inputs.
    logic [NNODE*MXPATB-1:0] node_pat;
    logic [NNODE*MXKEYB-1:0] node_key;
    logic [NSTG:0]           node_vld;
`ifdef BEST_1OFN_TIE_FLAG_EN
    logic [NNODE-1:0]        node_tie;
    assign node_tie[NPAT-1:0] = '0;
`endif

    assign node_pat[NPAT*MXPATB-1:0] = pat_in;
    assign node_key[NPAT*MXKEYB-1:0] = '0;
    assign node_vld[0] = pat_vld_in;

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int unsigned IB = 2 * NPAT - 2 * (NPAT >> s);
        localparam int unsigned OB = 2 * NPAT - 2 * (NPAT >> (s + 1));
        localparam int unsigned NO = NPAT >> (s + 1);

        for (genvar i = 0; i < NO; i++) begin : g_node
            logic [MXPATB-1:0] lo_pat, hi_pat, win_pat, stg_pat;
            logic [MXKEYB-1:0] lo_key, hi_key, win_key, stg_key;
            logic              up_win;

            assign lo_pat = node_pat[(IB + 2 * i) * MXPATB +: MXPATB];
            assign hi_pat = node_pat[(IB + 2 * i + 1) * MXPATB +: MXPATB];
            assign lo_key = node_key[(IB + 2 * i) * MXKEYB +: MXKEYB];
            assign hi_key = node_key[(IB + 2 * i + 1) * MXKEYB +: MXKEYB];

            // Strict compare: ties resolve to the lower key.
            assign up_win  = hi_pat[MXPATB-1:SORT_LSB] > lo_pat[MXPATB-1:SORT_LSB];
            assign win_pat = up_win ? hi_pat : lo_pat;

            always_comb begin
                win_key    = up_win ? hi_key : lo_key;
                win_key[s] = up_win;
            end

`ifdef BEST_1OFN_TIE_FLAG_EN
            logic win_tie, stg_tie;
            assign win_tie = (hi_pat[MXPATB-1:SORT_LSB] == lo_pat[MXPATB-1:SORT_LSB])
                           | (up_win ? node_tie[IB + 2 * i + 1] : node_tie[IB + 2 * i]);
            assign node_tie[OB + i] = stg_tie;
`endif

            if (PIPE_MASK[s]) begin : g_reg
                logic [MXPATB-1:0] pat_q;
                logic [MXKEYB-1:0] key_q;
`ifdef BEST_1OFN_TIE_FLAG_EN
                logic tie_q;
`endif
                always_ff @(posedge clock) begin
                    if (reset) begin
                        pat_q <= '0;
                        key_q <= '0;
`ifdef BEST_1OFN_TIE_FLAG_EN
                        tie_q <= 1'b0;
`endif
                    end else begin
                        pat_q <= win_pat;
                        key_q <= win_key;
`ifdef BEST_1OFN_TIE_FLAG_EN
                        tie_q <= win_tie;
`endif
                    end
                end
                assign stg_pat = pat_q;
                assign stg_key = key_q;
`ifdef BEST_1OFN_TIE_FLAG_EN
                assign stg_tie = tie_q;
`endif
            end else begin : g_comb
                assign stg_pat = win_pat;
                assign stg_key = win_key;
`ifdef BEST_1OFN_TIE_FLAG_EN
                assign stg_tie = win_tie;
`endif
            end

            assign node_pat[(OB + i) * MXPATB +: MXPATB] = stg_pat;
            assign node_key[(OB + i) * MXKEYB +: MXKEYB] = stg_key;
        end

        if (PIPE_MASK[s]) begin : g_vld_reg
            logic vld_q;
            always_ff @(posedge clock) begin
                if (reset) vld_q <= 1'b0;
                else       vld_q <= node_vld[s];
            end
            assign node_vld[s+1] = vld_q;
        end else begin : g_vld_comb
            assign node_vld[s+1] = node_vld[s];
        end
    end

    assign best_pat = node_pat[(NNODE - 1) * MXPATB +: MXPATB];
    assign best_key = node_key[(NNODE - 1) * MXKEYB +: MXKEYB];
    assign best_vld = node_vld[NSTG] && (best_pat[MXPATB-1:SORT_LSB] >= thresh);
`ifdef BEST_1OFN_TIE_FLAG_EN
    assign best_tie = node_tie[NNODE - 1];
`endif

    logic [MXCNTB-1:0] cnt_q;

    // Clear beats a concurrent increment.
    always_ff @(posedge clock) begin
        if (reset || cnt_clr)              cnt_q <= '0;
        else if (best_vld && cnt_q != '1)  cnt_q <= cnt_q + MXCNTB'(1);
    end

    assign best_cnt = cnt_q;

endmodule

// File: tb/tb_best_1ofn_pipe.sv
// Directed bench for best_1ofn_pipe: default 32-input build, a 64-input build with three
// pipeline stages, and a 4-bit counter build for saturation and clear priority.
module tb_best_1ofn_pipe;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Default instance: NPAT=32, L=1
    logic [32*7-1:0] pat_a;
    logic            vld_a, clr_a, bvld_a;
    logic [5:0]      thresh_a;
    logic [6:0]      bpat_a;
    logic [4:0]      bkey_a;
    logic [15:0]     bcnt_a;
    // NPAT=64, stages 1,3,5 registered, L=3
    logic [64*7-1:0] pat_b;
    logic            vld_b, clr_b, bvld_b;
    logic [5:0]      thresh_b;
    logic [6:0]      bpat_b;
    logic [5:0]      bkey_b;
    logic [15:0]     bcnt_b;
    // 4-bit counter instance, L=1
    logic [32*7-1:0] pat_c;
    logic            vld_c, clr_c, bvld_c;
    logic [5:0]      thresh_c;
    logic [6:0]      bpat_c;
    logic [4:0]      bkey_c;
    logic [3:0]      bcnt_c;
`ifdef BEST_1OFN_TIE_FLAG_EN
    logic tie_a, tie_b, tie_c;
`endif

    best_1ofn_pipe dut_a (
        .clock(clock), .reset(reset), .pat_in(pat_a), .pat_vld_in(vld_a), .thresh(thresh_a),
        .cnt_clr(clr_a), .best_pat(bpat_a), .best_key(bkey_a), .best_vld(bvld_a),
`ifdef BEST_1OFN_TIE_FLAG_EN
        .best_tie(tie_a),
`endif
        .best_cnt(bcnt_a)
    );

    best_1ofn_pipe #(.NPAT(64), .PIPE_MASK(8'b00101010)) dut_b (
        .clock(clock), .reset(reset), .pat_in(pat_b), .pat_vld_in(vld_b), .thresh(thresh_b),
        .cnt_clr(clr_b), .best_pat(bpat_b), .best_key(bkey_b), .best_vld(bvld_b),
`ifdef BEST_1OFN_TIE_FLAG_EN
        .best_tie(tie_b),
`endif
        .best_cnt(bcnt_b)
    );

    best_1ofn_pipe #(.MXCNTB(4)) dut_c (
        .clock(clock), .reset(reset), .pat_in(pat_c), .pat_vld_in(vld_c), .thresh(thresh_c),
        .cnt_clr(clr_c), .best_pat(bpat_c), .best_key(bkey_c), .best_vld(bvld_c),
`ifdef BEST_1OFN_TIE_FLAG_EN
        .best_tie(tie_c),
`endif
        .best_cnt(bcnt_c)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [6:0] exp_pat_b [3];
    logic [5:0] exp_key_b [3];

    initial begin
        reset = 1'b1;
        pat_a = '0; vld_a = 1'b0; clr_a = 1'b0; thresh_a = '0;
        pat_b = '0; vld_b = 1'b0; clr_b = 1'b0; thresh_b = '0;
        pat_c = '0; vld_c = 1'b0; clr_c = 1'b0; thresh_c = '0;

        // Live input during reset must not reach the outputs.
        pat_a[17*7 +: 7] = 7'h5A;
        vld_a = 1'b1;
        tick();
        tick();
        check_eq("rst_pat", 64'(bpat_a), 64'h0);
        check_eq("rst_key", 64'(bkey_a), 64'h0);
        check_eq("rst_vld", 64'(bvld_a), 64'h0);
        check_eq("rst_cnt", 64'(bcnt_a), 64'h0);

        // Single winner at key 17
        reset = 1'b0;
        tick();
        check_eq("k17_pat", 64'(bpat_a), 64'h5A);
        check_eq("k17_key", 64'(bkey_a), 64'd17);
        check_eq("k17_vld", 64'(bvld_a), 64'h1);
        vld_a = 1'b0;
        tick();
        check_eq("k17_cnt", 64'(bcnt_a), 64'd1);
        check_eq("k17_vld_off", 64'(bvld_a), 64'h0);

        // Equal sort values at keys 4, 9, 20: lowest key wins
        pat_a = '0;
        pat_a[4*7 +: 7]  = 7'h4C;
        pat_a[20*7 +: 7] = 7'h4C;
        pat_a[9*7 +: 7]  = 7'h4D;
        vld_a = 1'b1;
        tick();
        check_eq("tie_key", 64'(bkey_a), 64'd4);
        check_eq("tie_pat", 64'(bpat_a), 64'h4C);
        check_eq("tie_vld", 64'(bvld_a), 64'h1);
`ifdef BEST_1OFN_TIE_FLAG_EN
        check_eq("tie_flag", 64'(tie_a), 64'h1);
`endif

        // Threshold boundary: sort 1F fails, sort 20 passes
        thresh_a = 6'h20;
        pat_a = '0;
        pat_a[2*7 +: 7] = 7'h3F;
        tick();
        check_eq("thr_lo_vld", 64'(bvld_a), 64'h0);
        check_eq("thr_lo_pat", 64'(bpat_a), 64'h3F);
        check_eq("thr_lo_key", 64'(bkey_a), 64'd2);
        pat_a = '0;
        pat_a[5*7 +: 7] = 7'h40;
        tick();
        check_eq("thr_eq_vld", 64'(bvld_a), 64'h1);
        check_eq("thr_eq_pat", 64'(bpat_a), 64'h40);
        check_eq("thr_eq_key", 64'(bkey_a), 64'd5);
        vld_a = 1'b0;

        // NPAT=64, back-to-back winners 63, 0, 31 at latency 3
        exp_pat_b[0] = 7'h10; exp_key_b[0] = 6'd63;
        exp_pat_b[1] = 7'h22; exp_key_b[1] = 6'd0;
        exp_pat_b[2] = 7'h33; exp_key_b[2] = 6'd31;
        for (int c = 0; c < 6; c++) begin
            pat_b = '0;
            vld_b = (c < 3);
            if (c < 3) pat_b[int'(exp_key_b[c])*7 +: 7] = exp_pat_b[c];
            tick();
            if (c < 2) begin
                check_eq($sformatf("p64_early%0d_vld", c), 64'(bvld_b), 64'h0);
            end else if (c < 5) begin
                check_eq($sformatf("p64_r%0d_vld", c - 2), 64'(bvld_b), 64'h1);
                check_eq($sformatf("p64_r%0d_key", c - 2), 64'(bkey_b), 64'(exp_key_b[c-2]));
                check_eq($sformatf("p64_r%0d_pat", c - 2), 64'(bpat_b), 64'(exp_pat_b[c-2]));
            end else begin
                check_eq("p64_tail_vld", 64'(bvld_b), 64'h0);
            end
        end
        tick();
        check_eq("p64_cnt", 64'(bcnt_b), 64'd3);

        // Reset mid-stream drops in-flight results
        pat_b = '0;
        pat_b[10*7 +: 7] = 7'h11;
        vld_b = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_vld", 64'(bvld_b), 64'h0);
        check_eq("mid_rst_pat", 64'(bpat_b), 64'h0);
        check_eq("mid_rst_key", 64'(bkey_b), 64'h0);
        check_eq("mid_rst_cnt", 64'(bcnt_b), 64'h0);
        reset = 1'b0;
        vld_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("drop%0d_vld", c), 64'(bvld_b), 64'h0);
        end
        pat_b = '0;
        pat_b[7*7 +: 7] = 7'h55;
        vld_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vld_b = 1'b0;
            if (c < 2) check_eq($sformatf("post_rst%0d_vld", c), 64'(bvld_b), 64'h0);
        end
        check_eq("post_rst_vld", 64'(bvld_b), 64'h1);
        check_eq("post_rst_key", 64'(bkey_b), 64'd7);
        check_eq("post_rst_pat", 64'(bpat_b), 64'h55);

        // 4-bit counter: saturate at 15, clear with the 18th result, end at 2
        check_eq("c4_start", 64'(bcnt_c), 64'h0);
        pat_c = '0;
        pat_c[0 +: 7] = 7'h01;
        for (int e = 1; e <= 22; e++) begin
            vld_c = (e <= 20);
            clr_c = (e == 19);
            tick();
            case (e)
                16: check_eq("c4_sat15", 64'(bcnt_c), 64'd15);
                17: check_eq("c4_hold17", 64'(bcnt_c), 64'd15);
                18: check_eq("c4_hold18", 64'(bcnt_c), 64'd15);
                19: check_eq("c4_clear", 64'(bcnt_c), 64'd0);
                20: check_eq("c4_one", 64'(bcnt_c), 64'd1);
                21: check_eq("c4_two", 64'(bcnt_c), 64'd2);
                22: check_eq("c4_end", 64'(bcnt_c), 64'd2);
                default: ;
            endcase
        end
        clr_c = 1'b0;
        vld_c = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/best_1ofn_pipe.md
Name: best_1ofn_pipe

Overview:
- Parametrised successor to the fixed 32-input best-pattern sorter: selects the best 1 of NPAT 1/2-strip pattern words via a compare-by-twos tree and returns pattern, key and a qualified valid.
- Pipeline register placement is set per tree stage by parameter; valid travels with the data; a programmable threshold qualifies the result.
- A saturating counter tallies qualified results for the trigger-monitoring registers.
- Sits between the per-key pattern finders and the CLCT builder.

Parameters:
- NPAT, 32, number of input patterns; power of 2, 2..256
- MXPATB, 7, pattern word bits
- SORT_LSB, 1, number of low pattern bits ignored during sort (bend-direction bit)
- MXKEYB, clog2(NPAT), key bits (derived; not overridden)
- PIPE_MASK, 8'b00001000, bit s set = register after tree stage s (stage 0 = leaf compare); bits at or above log2(NPAT) ignored
- MXCNTB, 16, qualified-result counter width

Ports:
- clock, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- pat_in, in, NPAT*MXPATB, flattened patterns; key k at bits [k*MXPATB +: MXPATB]
- pat_vld_in, in, 1, pat_in valid this cycle
- thresh, in, MXPATB-SORT_LSB, minimum sort value for a qualified result; quasi-static
- cnt_clr, in, 1, clear qualified-result counter
- best_pat, out, MXPATB, winning pattern word (full width, including ignored LSBs)
- best_key, out, MXKEYB, winning key
- best_vld, out, 1, pipelined pat_vld_in AND sort(best_pat) >= thresh
- best_cnt, out, MXCNTB, saturating count of cycles with best_vld=1

Behaviour:
- sort(p) = p[MXPATB-1:SORT_LSB], unsigned.
- Stage s compares pairs (2i+1, 2i). Upper wins only if sort(upper) > sort(lower); ties go to lower, so the lowest key wins any tie overall.
- Key bit s is set to 1 when the upper element wins at stage s; key MSB = final stage.
- Latency L = popcount(PIPE_MASK[log2(NPAT)-1:0]) cycles from pat_in/pat_vld_in to best_*.
- L=0 is purely combinational except the counter.
- Valid pipeline is L flops deep and registered at exactly the same stages as the data.
- best_vld is evaluated after the final stage: pipelined valid AND sort(best_pat) >= thresh.
  - thresh=0: every valid input qualifies, including all-zero patterns.
- best_pat/best_key update every cycle regardless of valid. The consumer uses best_vld only.
- No stall and no backpressure. A new input is accepted every cycle; throughput 1 per clock.
- Reset clears all pipeline data, key and valid registers to 0, so outputs read 0 during and after reset until real data propagates.
  - Reset mid-stream drops all in-flight results. First best_vld possible L cycles after the first valid input following reset release.
- best_cnt:
  - Increments on each cycle best_vld=1; holds at all-ones (saturates, no wrap).
  - reset or cnt_clr forces 0.
  - cnt_clr and best_vld in the same cycle: clear wins, count becomes 0, not 1.
  - best_cnt is registered, so it reflects best_vld one cycle later.
- NPAT=2: single stage. The key is 1 bit and only PIPE_MASK[0] is meaningful.

Optional Feature:
- Macro: BEST_1OFN_TIE_FLAG_EN
- Defined: adds output best_tie (1 bit, reset 0), pipelined identically to best_pat.
  - At each compare: tie_out = (sort(a)==sort(b)) | tie of winner.
  - Leaf ties start at 0.
  - best_tie=1 means at least one other input along the winner's comparison path had an equal sort value.
- Not defined: port absent, no tie logic; all other behaviour identical.

Test Plan:
- NPAT=32, PIPE_MASK default, all patterns 0 except key 17 = 7'h5A, thresh=0, vld=1 -> after 1 clk: best_pat=5A, best_key=17, best_vld=1, best_cnt=1 one clk later.
- Keys 4 and 20 both 7'h4C, key 9 = 7'h4D (sort equal to 4C), all else 0 -> best_key=4, best_pat=4C; with TIE_FLAG_EN, best_tie=1.
- NPAT=64, PIPE_MASK=6'b101010, back-to-back vectors, best key 63 then 0 then 31 -> results at latency 3 in order 63, 0, 31, best_vld high 3 consecutive cycles.
- thresh=6'h20, best sort value 6'h1F then 6'h20 -> best_vld=0 then 1; best_pat valid on both cycles.
- Drive valid stream, assert reset for 1 clk mid-flight -> all in-flight best_vld suppressed, best_* = 0, best_cnt=0; next valid input emerges after L clocks.
- MXCNTB=4, 20 qualified results with cnt_clr pulsed concurrently with the 18th -> best_cnt saturates at 15, drops to 0 at the clear, ends at 2.
